// File: rtl/ebpf_sched_pkg.sv
// Shared types and constants for the eBPF job scheduler: FSM states, CSR bit
// positions, response codes and the result record.
package ebpf_sched_pkg;
  localparam int ARG_W = 320;

  typedef enum logic [2:0] {IDLE, LOAD, RUN, DRAIN, RESP} state_t;

  localparam int CSR_CTL_RUN = 0;
  localparam int CSR_ST_BUSY = 0;
  localparam int CSR_ST_DONE = 1;
  localparam int CSR_ST_ERR  = 2;

  localparam logic [1:0] RESP_OK      = 2'd0;
  localparam logic [1:0] RESP_CPU_ERR = 2'd1;
  localparam logic [1:0] RESP_TIMEOUT = 2'd2;

  typedef struct packed {
    logic [63:0] r0;
    logic [1:0]  code;
    logic [63:0] ticks;
  } resp_t;
endpackage

// File: rtl/ebpf_job_sched_if.sv
// Requester-side bus: per-requester job handshake plus shared result fields.
interface ebpf_job_sched_if
  import ebpf_sched_pkg::*;
#(parameter int N_REQ = 4);
  logic [N_REQ-1:0]            req_valid;
  logic [N_REQ-1:0]            req_ready;
  logic [N_REQ-1:0][ARG_W-1:0] req_args;
  logic [N_REQ-1:0]            resp_valid;
  logic [N_REQ-1:0]            resp_ready;
  logic [63:0]                 resp_r0;
  logic [1:0]                  resp_code;
  logic [63:0]                 resp_ticks;

  modport master (output req_valid, req_args, resp_ready,
                  input  req_ready, resp_valid, resp_r0, resp_code, resp_ticks);
  modport slave  (input  req_valid, req_args, resp_ready,
                  output req_ready, resp_valid, resp_r0, resp_code, resp_ticks);
endinterface

// File: rtl/ebpf_job_sched_rr_arbiter.sv
// Combinational round-robin pick: first set req bit at or above ptr, circularly.
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx
);
  int j;

  // Scan from the farthest candidate back to ptr so the nearest one wins last.
  always_comb begin
    grant = '0;
    idx   = '0;
    j     = 0;
    for (int i = N - 1; i >= 0; i--) begin
      j = (int'(ptr) + i) % N;
      if (req[j]) begin
        grant    = '0;
        grant[j] = 1'b1;
        idx      = IW'(j);
      end
    end
  end
endmodule

// File: rtl/ebpf_job_sched.sv
// Runs eBPF jobs from N requesters on one shared cpu: round-robin accept, load
// r1..r5, drive RUN under a watchdog, then hand r0/code/ticks back to the owner.
module ebpf_job_sched
  import ebpf_sched_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic                clock,
  input  logic                reset_n,
  ebpf_job_sched_if.slave     bus,
  output logic [7:0]          cpu_csr_ctl,
  input  logic [7:0]          cpu_csr_status,
  output logic [63:0]         cpu_r1,
  output logic [63:0]         cpu_r2,
  output logic [63:0]         cpu_r3,
  output logic [63:0]         cpu_r4,
  output logic [63:0]         cpu_r5,
  input  logic [63:0]         cpu_r0,
  input  logic [63:0]         cpu_ticks,
  output logic                busy,
  output logic [31:0]         jobs_done
);
  localparam int          IW      = $clog2(N_REQ);
  localparam logic [31:0] WD_LAST = 32'(TIMEOUT_CYC - 1);

  state_t                 state;
  logic [N_REQ-1:0]       grant;
  logic [IW-1:0]          grant_idx, owner, rr_ptr;
  logic [ARG_W-1:0]       args_q;
  logic [4:0][63:0]       regs_q;
  logic                   run_q;
  logic [31:0]            wdog;
  logic [63:0]            start_ticks;
  resp_t                  res_q;
  logic [N_REQ-1:0]       resp_vld_q;
  logic [31:0]            done_cnt;
  logic                   st_busy, st_done, st_err;
  logic [4:0]             unused_status;

  assign st_busy       = cpu_csr_status[CSR_ST_BUSY];
  assign st_done       = cpu_csr_status[CSR_ST_DONE];
  assign st_err        = cpu_csr_status[CSR_ST_ERR];
  assign unused_status = cpu_csr_status[7:3];

  rr_arbiter #(.N(N_REQ)) u_arb (
    .req   (bus.req_valid),
    .ptr   (rr_ptr),
    .grant (grant),
    .idx   (grant_idx)
  );

  assign bus.req_ready = (state == IDLE) ? grant : '0;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      owner       <= '0;
      rr_ptr      <= '0;
      args_q      <= '0;
      regs_q      <= '0;
      run_q       <= 1'b0;
      wdog        <= '0;
      start_ticks <= '0;
      res_q       <= '0;
      resp_vld_q  <= '0;
      done_cnt    <= '0;
    end else begin
      case (state)
        IDLE: if (|grant) begin
          args_q <= bus.req_args[grant_idx];
          owner  <= grant_idx;
          state  <= LOAD;
        end
        LOAD: begin
          regs_q      <= args_q;
          start_ticks <= cpu_ticks;
          wdog        <= '0;
          run_q       <= 1'b1;
          state       <= RUN;
        end
        RUN: begin
          // ERR outranks DONE, and both outrank the watchdog in the same cycle.
          if (st_err || st_done || wdog == WD_LAST) begin
            run_q       <= 1'b0;
            res_q.ticks <= cpu_ticks - start_ticks;
            state       <= DRAIN;
            if (st_err) begin
              res_q.code <= RESP_CPU_ERR;
              res_q.r0   <= cpu_r0;
            end else if (st_done) begin
              res_q.code <= RESP_OK;
              res_q.r0   <= cpu_r0;
            end else begin
              res_q.code <= RESP_TIMEOUT;
              res_q.r0   <= '0;
            end
          end else begin
            wdog <= wdog + 32'd1;
          end
        end
        DRAIN: if (!st_busy && !st_done) begin
          resp_vld_q <= {{(N_REQ-1){1'b0}}, 1'b1} << owner;
          state      <= RESP;
        end
        RESP: if (bus.resp_ready[owner]) begin
          resp_vld_q <= '0;
          done_cnt   <= done_cnt + 32'd1;
          rr_ptr     <= (owner == IW'(N_REQ - 1)) ? '0 : owner + IW'(1);
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign cpu_csr_ctl    = 8'(run_q) << CSR_CTL_RUN;
  assign cpu_r1         = regs_q[0];
  assign cpu_r2         = regs_q[1];
  assign cpu_r3         = regs_q[2];
  assign cpu_r4         = regs_q[3];
  assign cpu_r5         = regs_q[4];
  assign busy           = (state != IDLE);
  assign jobs_done      = done_cnt;
  assign bus.resp_valid = resp_vld_q;
  assign bus.resp_r0    = res_q.r0;
  assign bus.resp_code  = res_q.code;
  assign bus.resp_ticks = res_q.ticks;
endmodule
